mips8_memory_responder: RTL and testbench
=========================================

Name: mips8_memory_responder

Overview:
- Memory-side responder for the 8-bit multicycle MIPS processor's byte memory port; answers memread/memwrite/adr/writedata with memdata.
- Adds a byte-serial program loader: after reset the block holds the processor in reset, streams an image into RAM through a valid/ready handshake, then releases the processor.
- Sits beside the processor in the system top.

Parameters:
- DEPTH, 256, number of byte locations; the address is always 8 bits, and DEPTH must be 256.
- BOOT_LOAD, 1, 1 = start in LOAD after reset; 0 = start directly in RUN with hold deasserted.
- PROT_LIMIT, 8'h40, first writable address when MEM_WRITE_PROTECT_EN is defined.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- memread  input  1  processor read strobe
- memwrite  input  1  processor write strobe
- adr  input  8  processor byte address
- writedata  input  8  processor write data
- memdata  output  8  registered read data to processor
- load_valid  input  1  loader byte present
- load_data  input  8  loader byte
- load_last  input  1  qualifies final loader byte
- load_ready  output  1  block accepts loader byte this cycle
- cpu_hold  output  1  drives the processor's reset input; 1 = processor held
- load_ovf  output  1  sticky: load pointer wrapped past 8'hFF
- prot_fault  output  1  one-cycle pulse on a blocked write (feature only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, asynchronous):
  - memdata=0, load_ready=0, load_ovf=0, prot_fault=0.
  - Load pointer = 0.
  - State = LOAD with cpu_hold=1 if BOOT_LOAD=1; otherwise state = RUN with cpu_hold=0.
  - RAM contents are not reset.
- States: LOAD, RUN. There is no return to LOAD except through reset.
- LOAD:
  - load_ready=1 (registered; first asserted the cycle after reset deasserts).
  - Handshake: a byte transfers on a clock edge where load_valid=1 and load_ready=1.
  - On transfer, load_data is written to RAM[ptr] and ptr increments by 1 modulo 256.
  - When ptr wraps from 8'hFF to 0, load_ovf is set and stays set until reset.
  - A transfer with load_last=1 writes its byte, then moves to RUN on the same edge. From the next cycle: load_ready=0, cpu_hold=0.
  - load_last with load_valid=0 is ignored.
  - memread/memwrite are ignored in LOAD, and memdata holds its value.
- RUN:
  - load_ready=0; load_valid is ignored.
  - Read: on an edge where memread=1 and memwrite=0, memdata <= RAM[adr]. One-cycle latency: data is valid in the cycle after the strobe and holds until the next read.
  - Write: on an edge where memwrite=1, RAM[adr] <= writedata and memdata holds.
  - Simultaneous memread and memwrite: the write executes and the read is suppressed.
  - A read of an address written on the previous edge returns the new data.
- Reset mid-load:
  - The partial image remains in RAM.
  - ptr restarts at 0 and the handshake restarts cleanly.
  - No spurious write occurs on the reset edge.

Optional Feature:
- Macro: MEM_WRITE_PROTECT_EN.
- Defined:
  - In RUN, a memwrite to adr < PROT_LIMIT is dropped; RAM is unchanged.
  - prot_fault pulses high for exactly one cycle, on the cycle after the blocked edge.
  - LOAD writes are never protected.
  - A blocked write also suppresses a simultaneous read.
- Undefined: no protection logic; prot_fault is tied to 0.

Test Plan:
- Reset, then stream 4 bytes 8'h20,8'h02,8'h00,8'h05 with load_last on the 4th -> RAM[0..3] holds those values; load_ready drops and cpu_hold=0 one cycle after the 4th transfer; load_ovf=0.
- RUN: memread adr=8'h02 -> memdata=8'h00 on the next cycle; memwrite adr=8'h80 data=8'hA5, then memread adr=8'h80 -> memdata=8'hA5.
- RUN: memread and memwrite together at adr=8'h81, data=8'h3C -> RAM[8'h81]=8'h3C and memdata unchanged that cycle.
- LOAD: 257 bytes with load_valid held at 1 and load_last on the 257th -> load_ovf=1; RAM[0] holds the 257th byte.
- Assert reset after 2 of 4 loader bytes -> cpu_hold stays 1; reload 4 bytes from ptr 0 -> correct image; memdata=0 after reset.
- With MEM_WRITE_PROTECT_EN: RUN memwrite adr=8'h10 data=8'hFF -> RAM[8'h10] unchanged, prot_fault=1 for one cycle; write adr=8'h40 succeeds with no fault.

Source files
------------

// File: rtl/mips8_memory_responder.sv
// mips8_memory_responder
//   Byte memory responder for the 8-bit multicycle MIPS core, with a byte-serial boot loader.
//   After reset the block can hold the processor in reset (cpu_hold_o) and stream an image
//   into RAM through a valid/ready handshake. The final byte carries load_last_i, and that
//   transfer releases the processor.
//
//   Optional feature macro: MEM_WRITE_PROTECT_EN
//     When defined, RUN-state writes below PROT_LIMIT are dropped and prot_fault_o pulses.
//     When undefined, prot_fault_o is tied low.
//
// Ports:
//   clk_i         system clock, rising edge
//   reset_ni      asynchronous active-low reset
//   memread_i     processor read strobe
//   memwrite_i    processor write strobe
//   adr_i         processor byte address
//   writedata_i   processor write data
//   memdata_o     registered read data (one-cycle latency)
//   load_valid_i  loader byte present
//   load_data_i   loader byte
//   load_last_i   marks the final loader byte
//   load_ready_o  loader byte accepted this cycle
//   cpu_hold_o    processor reset request (1 = held)
//   load_ovf_o    sticky: load pointer wrapped past 8'hFF
//   prot_fault_o  one-cycle pulse after a blocked write
module mips8_memory_responder #(
    parameter int unsigned DEPTH      = 256,   // must be 256: the address is always 8 bits
    parameter int unsigned BOOT_LOAD  = 1,
    parameter logic [7:0]  PROT_LIMIT = 8'h40
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       memread_i,
    input  logic       memwrite_i,
    input  logic [7:0] adr_i,
    input  logic [7:0] writedata_i,
    output logic [7:0] memdata_o,
    input  logic       load_valid_i,
    input  logic [7:0] load_data_i,
    input  logic       load_last_i,
    output logic       load_ready_o,
    output logic       cpu_hold_o,
    output logic       load_ovf_o,
    output logic       prot_fault_o
);

    typedef enum logic [0:0] {StLoad, StRun} state_e;

    state_e     state_q;
    logic [7:0] mem_q [DEPTH];
    logic [7:0] ptr_q;
    logic [7:0] memdata_q;
    logic       load_ready_q;
    logic       load_ovf_q;

    logic load_xfer;
    logic run_wr;
    logic run_rd;
    logic wr_blocked;

    // load_ready_q is 0 throughout reset, so nothing transfers on the reset-release edge.
    assign load_xfer = (state_q == StLoad) && load_valid_i && load_ready_q;

`ifdef MEM_WRITE_PROTECT_EN
    logic prot_fault_q;

    assign wr_blocked = (state_q == StRun) && memwrite_i && (adr_i < PROT_LIMIT);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prot_fault_q <= 1'b0;
        end else begin
            prot_fault_q <= wr_blocked;
        end
    end

    assign prot_fault_o = prot_fault_q;
`else
    logic unused_prot_limit;

    assign unused_prot_limit = ^PROT_LIMIT;
    assign wr_blocked        = 1'b0;
    assign prot_fault_o      = 1'b0;
`endif

    assign run_wr = (state_q == StRun) && memwrite_i && !wr_blocked;
    // Any write strobe, including a blocked one, suppresses a read on the same edge.
    assign run_rd = (state_q == StRun) && memread_i && !memwrite_i;

    // RAM contents deliberately survive reset so a partial image stays in place.
    always_ff @(posedge clk_i) begin
        if (load_xfer) begin
            mem_q[ptr_q] <= load_data_i;
        end else if (run_wr) begin
            mem_q[adr_i] <= writedata_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= (BOOT_LOAD != 0) ? StLoad : StRun;
            ptr_q        <= 8'h00;
            memdata_q    <= 8'h00;
            load_ready_q <= 1'b0;
            load_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    load_ready_q <= 1'b1;
                    if (load_xfer) begin
                        ptr_q <= ptr_q + 8'd1;
                        if (ptr_q == 8'hFF) begin
                            load_ovf_q <= 1'b1;
                        end
                        if (load_last_i) begin
                            state_q      <= StRun;
                            load_ready_q <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    load_ready_q <= 1'b0;
                    if (run_rd) begin
                        memdata_q <= mem_q[adr_i];
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign memdata_o    = memdata_q;
    assign load_ready_o = load_ready_q;
    assign cpu_hold_o   = (state_q == StLoad);
    assign load_ovf_o   = load_ovf_q;

endmodule

// File: tb/tb_mips8_memory_responder.sv
// Testbench for mips8_memory_responder: vector table, random RUN traffic against a
// behavioural memory model, and hand-written reset and overflow sequences.
module tb_mips8_memory_responder;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic       memread_i, memwrite_i;
    logic [7:0] adr_i, writedata_i;
    logic [7:0] memdata_o;
    logic       load_valid_i;
    logic [7:0] load_data_i;
    logic       load_last_i;
    logic       load_ready_o, cpu_hold_o, load_ovf_o, prot_fault_o;

    mips8_memory_responder dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .memread_i    (memread_i),
        .memwrite_i   (memwrite_i),
        .adr_i        (adr_i),
        .writedata_i  (writedata_i),
        .memdata_o    (memdata_o),
        .load_valid_i (load_valid_i),
        .load_data_i  (load_data_i),
        .load_last_i  (load_last_i),
        .load_ready_o (load_ready_o),
        .cpu_hold_o   (cpu_hold_o),
        .load_ovf_o   (load_ovf_o),
        .prot_fault_o (prot_fault_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: memory image plus the externally visible registers.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    bit         m_load;
    bit         m_ready;
    bit         m_ovf;
    bit         m_fault;
    bit [7:0]   m_ptr;
    logic [7:0] m_md;
    bit         m_md_known;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [7:0] a;
        logic [7:0] wd;
        bit         lv;
        logic [7:0] ld;
        bit         ll;
        logic [7:0] md;
        bit         rdy;
        bit         hold;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rd, input bit wr, input logic [7:0] a,
                              input logic [7:0] wd, input bit lv, input logic [7:0] ld,
                              input bit ll);
        bit blk;
        blk = 1'b0;
        if (m_load) begin
            m_fault = 1'b0;
            if (lv && m_ready) begin
                m_mem[m_ptr]   = ld;
                m_known[m_ptr] = 1'b1;
                if (m_ptr == 8'hFF) m_ovf = 1'b1;
                m_ptr = m_ptr + 8'd1;
                if (ll) m_load = 1'b0;
            end
        end else begin
`ifdef MEM_WRITE_PROTECT_EN
            blk = wr && (a < 8'h40);
`endif
            m_fault = blk;
            if (wr && !blk) begin
                m_mem[a]   = wd;
                m_known[a] = 1'b1;
            end else if (rd && !wr) begin
                m_md       = m_mem[a];
                m_md_known = m_known[a];
            end
        end
        m_ready = m_load;
    endtask

    // Drive one cycle of inputs, advance the model and the DUT by one edge.
    task automatic step(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input bit lv, input logic [7:0] ld, input bit ll);
        memread_i    = rd;
        memwrite_i   = wr;
        adr_i        = a;
        writedata_i  = wd;
        load_valid_i = lv;
        load_data_i  = ld;
        load_last_i  = ll;
        model_edge(rd, wr, a, wd, lv, ld, ll);
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_model(input string tag);
        if (m_md_known) chk({tag, "_memdata"}, memdata_o, m_md);
        chk({tag, "_ready"}, {7'b0, load_ready_o}, {7'b0, m_ready});
        chk({tag, "_hold"},  {7'b0, cpu_hold_o},   {7'b0, m_load});
        chk({tag, "_ovf"},   {7'b0, load_ovf_o},   {7'b0, m_ovf});
        chk({tag, "_fault"}, {7'b0, prot_fault_o}, {7'b0, m_fault});
    endtask

    task automatic do_reset();
        reset_ni     = 1'b0;
        memread_i    = 1'b0;
        memwrite_i   = 1'b0;
        adr_i        = 8'h00;
        writedata_i  = 8'h00;
        load_valid_i = 1'b0;
        load_data_i  = 8'h00;
        load_last_i  = 1'b0;
        m_load = 1'b1; m_ready = 1'b0; m_ovf = 1'b0; m_fault = 1'b0;
        m_ptr = 8'h00; m_md = 8'h00; m_md_known = 1'b1;
        #3;
        check_model("in_reset");
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        check_model("after_release");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

        tbl[0]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h20, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h05, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0, 8'h05, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h80, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'h80, 8'h00, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 8'h81, 8'h3C, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h81, 8'h00, 1'b0, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h77, 1'b1, 8'h3C, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 8'h82, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 8'h82, 8'h00, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0};

        do_reset();

        // Boot 4 bytes, then basic RUN reads/writes.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].lv, tbl[i].ld, tbl[i].ll);
            chk($sformatf("tbl%0d_memdata", i), memdata_o, tbl[i].md);
            chk($sformatf("tbl%0d_ready", i), {7'b0, load_ready_o}, {7'b0, tbl[i].rdy});
            chk($sformatf("tbl%0d_hold", i), {7'b0, cpu_hold_o}, {7'b0, tbl[i].hold});
            chk($sformatf("tbl%0d_ovf", i), {7'b0, load_ovf_o}, 8'h00);
            chk($sformatf("tbl%0d_fault", i), {7'b0, prot_fault_o}, 8'h00);
        end

        // Random RUN traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom),
                 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            check_model("rand");
        end

        // Reset after 2 of 4 loader bytes, then reload from pointer 0.
        do_reset();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0);
        check_model("partial");
        do_reset();
        chk("midload_hold", {7'b0, cpu_hold_o}, 8'h01);
        chk("midload_memdata", memdata_o, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hBB, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hCC, 1'b0);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hDD, 1'b1);
        check_model("reload");
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reload_b0", memdata_o, 8'hAA);
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reload_b1", memdata_o, 8'hBB);
        step(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reload_b2", memdata_o, 8'hCC);
        step(1'b1, 1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reload_b3", memdata_o, 8'hDD);
        chk("reload_ovf", {7'b0, load_ovf_o}, 8'h00);

        // 257-byte load wraps the pointer.
        do_reset();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 257; i++) begin
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'(i * 13 + 7), (i == 256));
            check_model("wrap");
        end
        chk("wrap_ovf", {7'b0, load_ovf_o}, 8'h01);
        chk("wrap_hold", {7'b0, cpu_hold_o}, 8'h00);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("wrap_ram0", memdata_o, 8'(256 * 13 + 7));
        step(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("wrap_ramff", memdata_o, 8'(255 * 13 + 7));

        // Write to low memory, then to the first writable address.
        step(1'b0, 1'b1, 8'h10, 8'hFF, 1'b0, 8'h00, 1'b0);
        check_model("prot_wr");
`ifdef MEM_WRITE_PROTECT_EN
        chk("prot_fault_pulse", {7'b0, prot_fault_o}, 8'h01);
`else
        chk("prot_fault_pulse", {7'b0, prot_fault_o}, 8'h00);
`endif
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("prot_fault_clear", {7'b0, prot_fault_o}, 8'h00);
        step(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef MEM_WRITE_PROTECT_EN
        chk("prot_ram10", memdata_o, 8'(16 * 13 + 7));
`else
        chk("prot_ram10", memdata_o, 8'hFF);
`endif
        step(1'b0, 1'b1, 8'h40, 8'h99, 1'b0, 8'h00, 1'b0);
        chk("prot_limit_fault", {7'b0, prot_fault_o}, 8'h00);
        step(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("prot_limit_ram", memdata_o, 8'h99);
        check_model("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
